// File: rtl/prog_mem_loader.sv
// Program-memory write loader: streams instruction words into addresses 0.., pads the
// remainder with FILL_WORD, holds the CPU while busy, and reports count/checksum/overflow.
module prog_mem_loader #(
  parameter int                      DATA_SIZE = 6,
  parameter int                      ADDR_SIZE = 5,
  parameter logic [DATA_SIZE-1:0]    FILL_WORD = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 in_last,
  output logic                 wr_en,
  output logic [ADDR_SIZE-1:0] wr_addr,
  output logic [DATA_SIZE-1:0] wr_data,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 err_overflow,
  output logic [ADDR_SIZE:0]   word_cnt,
  output logic [DATA_SIZE-1:0] checksum
);

  // Valid/ready: a word transfers on a rising edge where in_valid & in_ready are both 1;
  // in_ready depends only on the registered state, never on in_valid.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FILL  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = '1;

  state_t                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   ptr_q, ptr_d;
  logic                   in_ready_q, in_ready_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_SIZE-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_SIZE-1:0]   wr_data_q, wr_data_d;
  logic                   cpu_hold_q, cpu_hold_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [ADDR_SIZE:0]     cnt_q, cnt_d;
  logic [DATA_SIZE-1:0]   cs_q, cs_d;
  logic                   accept;

  assign accept = in_valid & in_ready_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    cs_d      = cs_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
          cs_d    = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = in_data;
          cnt_d     = cnt_q + 1'b1;
          cs_d      = cs_q ^ in_data;
          // The pointer parks on the last address instead of wrapping.
          if (ptr_q == LAST_ADDR) begin
            state_d = in_last ? S_DONE : S_DRAIN;
          end else begin
            ptr_d = ptr_q + 1'b1;
            if (in_last) state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        wr_en_d   = 1'b1;
        wr_addr_d = ptr_q;
        wr_data_d = FILL_WORD;
        if (ptr_q == LAST_ADDR) state_d = S_DONE;
        else                    ptr_d   = ptr_q + 1'b1;
      end
      S_DRAIN: begin
        if (accept) begin
          err_d = 1'b1;
          if (in_last) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_LOAD) || (state_d == S_DRAIN);
    cpu_hold_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      cs_q       <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      cs_q       <= cs_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign err_overflow = err_q;
  assign word_cnt     = cnt_q;
  assign checksum     = cs_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Bench for prog_mem_loader: directed loads plus random-length, random-gap loads checked
// against a memory-image model of the expected write sequence and status.
module tb_prog_mem_loader;

  localparam int DW    = 6;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int EW    = AW + DW;

  logic          clk;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          cpu_hold;
  logic          done;
  logic          err_overflow;
  logic [AW:0]   word_cnt;
  logic [DW-1:0] checksum;

  prog_mem_loader #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .FILL_WORD('0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cpu_hold(cpu_hold), .done(done), .err_overflow(err_overflow),
    .word_cnt(word_cnt), .checksum(checksum)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];
  logic [DW-1:0] words[$];

  // Capture every write strobe as {addr,data}, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && wr_en) got_q.push_back({wr_addr, wr_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("%s", tag);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_cpu_hold"}, cpu_hold, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err_overflow, 0);
    chk({tag, "_word_cnt"}, word_cnt, 0);
    chk({tag, "_checksum"}, checksum, 0);
  endtask

  // Driver tasks: each begins and ends just after a falling edge.
  task automatic do_start(input bit junk);
    start = 1'b1;
    if (junk) begin
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      in_last  = 1'b1;
    end
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("start_cpu_hold", cpu_hold, 1);
    chk("start_done_clr", done, 0);
    chk("start_in_ready", in_ready, 1);
    chk("start_word_cnt", word_cnt, 0);
  endtask

  task automatic send_word(input logic [DW-1:0] d, input bit last, input int gap,
                           input bit poke_start);
    int k = 0;
    int g;
    g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
    repeat (g) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    start    = poke_start;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("handshake_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
  endtask

  // Runs a full load of words[] and checks writes and status against the model.
  task automatic run_load(input string tag, input int gap, input bit junk, input int poke_at);
    int n, m, k, lim;
    logic [DW-1:0] exp_cs;
    n = words.size();
    m = (n < DEPTH) ? n : DEPTH;
    exp_q.delete();
    exp_cs = '0;
    for (int i = 0; i < m; i++) begin
      exp_q.push_back({AW'(i), words[i]});
      exp_cs ^= words[i];
    end
    for (int i = n; i < DEPTH; i++) exp_q.push_back({AW'(i), DW'(0)});
    got_q.delete();
    do_start(junk);
    for (int i = 0; i < n; i++) send_word(words[i], i == n - 1, gap, i == poke_at);
    k = 0;
    while (!(done && !cpu_hold) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_cpu_hold"}, cpu_hold, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_word_cnt"}, word_cnt, m);
    chk({tag, "_checksum"}, checksum, exp_cs);
    chk({tag, "_overflow"}, err_overflow, (n > DEPTH) ? 1 : 0);
    chk({tag, "_write_count"}, got_q.size(), exp_q.size());
    lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++)
      chk($sformatf("%s_write%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_cpu_hold", cpu_hold, 0);

    // Short program, back to back, with a word offered alongside start.
    words = '{6'h11, 6'h22, 6'h05};
    run_load("short", 0, 1'b1, -1);
    chk("short_checksum_const", checksum, 6'h36);
    chk("short_cnt_const", word_cnt, 3);

    // Same program with in_valid low on alternate cycles.
    words = '{6'h11, 6'h22, 6'h05};
    run_load("gapped", 1, 1'b0, -1);

    // Exactly full memory: no fill.
    words.delete();
    for (int i = 0; i < DEPTH; i++) words.push_back(DW'(i));
    run_load("full", 0, 1'b0, -1);
    chk("full_checksum_const", checksum, 0);

    // Overflow by two words.
    words.delete();
    for (int i = 0; i < DEPTH + 2; i++) words.push_back(DW'($urandom));
    run_load("overflow", -1, 1'b0, -1);
    chk("overflow_flag_const", err_overflow, 1);

    // Reset in the middle of a load.
    words.delete();
    for (int i = 0; i < 8; i++) words.push_back(DW'($urandom));
    do_start(1'b0);
    for (int i = 0; i < 5; i++) send_word(words[i], 1'b0, 0, 1'b0);
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_reset_in_ready", in_ready, 0);

    // Fresh load with a stray start pulse mid-load.
    words.delete();
    for (int i = 0; i < 9; i++) words.push_back(DW'($urandom));
    run_load("restart", -1, 1'b0, 3);

    // Random programs of random length.
    repeat (6) begin
      int n;
      n = $urandom_range(1, DEPTH + 8);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back(DW'($urandom));
      run_load($sformatf("rand_n%0d", n), -1, 1'($urandom_range(0, 1)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
